cfg_loader: RTL and testbench

CFG_LOADER -- requirements
Module: cfg_loader

---
 rtl/cfg_loader_if.sv | 11 +
 rtl/cfg_loader.sv | 136 +++++++++++++
 tb/tb_cfg_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_loader_if.sv
// Host word stream into the configuration loader.
interface cfg_loader_if #(
  parameter int unsigned WORD_W = 8
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cfg_loader.sv
// Serialises host words into a configuration chain, then recirculates the
// chain once while comparing a CRC of the returned bits against the load CRC.
module cfg_loader #(
  parameter int unsigned CHAIN_LEN = 48,
  parameter int unsigned WORD_W    = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         start,
  cfg_loader_if.slave  host,
  output logic         cfg_en,
  output logic         cfg_data,
  input  logic         cfg_ret,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int unsigned N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int unsigned CNT_W   = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BL_W    = $clog2(WORD_W + 1);
  localparam int unsigned WC_W    = $clog2(N_WORDS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY
  } state_e;

  state_e            state_q;
  logic [WORD_W-1:0] buf_q;
  logic [BL_W-1:0]   bits_left_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [WC_W-1:0]   word_cnt_q;
  logic [7:0]        crc_ld_q;
  logic [7:0]        crc_vf_q;
  logic [7:0]        crc_vf_d;
  logic              done_q;
  logic              err_q;

  logic              load_shift_c;
  logic              ready_c;
  logic              accept_c;

  // CRC-8 (poly 0x07), one serial bit, MSB first
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  assign load_shift_c = (state_q == S_LOAD) && (bits_left_q != '0);
  assign ready_c      = (state_q == S_LOAD) && (bits_left_q <= BL_W'(1))
                        && (word_cnt_q < WC_W'(N_WORDS));
  assign accept_c     = host.in_valid && ready_c;
  assign crc_vf_d     = crc8_step(crc_vf_q, cfg_ret);

  assign host.in_ready = ready_c;
  assign cfg_en        = load_shift_c || (state_q == S_VERIFY);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err           = err_q;

  // Loopback during verify keeps the chain content intact after a full rotation
  always_comb begin
    cfg_data = 1'b0;
    case (state_q)
      S_LOAD:   cfg_data = buf_q[WORD_W-1];
      S_VERIFY: cfg_data = cfg_ret;
      default:  cfg_data = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      bits_left_q <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      crc_ld_q    <= '0;
      crc_vf_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_LOAD;
            buf_q       <= '0;
            bits_left_q <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
            crc_ld_q    <= '0;
            crc_vf_q    <= '0;
            err_q       <= 1'b0;
          end
        end
        S_LOAD: begin
          if (load_shift_c) begin
            buf_q       <= {buf_q[WORD_W-2:0], 1'b0};
            bits_left_q <= bits_left_q - BL_W'(1);
            bit_cnt_q   <= bit_cnt_q + CNT_W'(1);
            crc_ld_q    <= crc8_step(crc_ld_q, buf_q[WORD_W-1]);
          end
          // A new word overrides the shift so the stream has no bubble
          if (accept_c) begin
            buf_q       <= host.in_data;
            bits_left_q <= BL_W'(WORD_W);
            word_cnt_q  <= word_cnt_q + WC_W'(1);
          end
          // Trailing bits of a partial final word are dropped here
          if (load_shift_c && (bit_cnt_q == CNT_W'(CHAIN_LEN - 1))) begin
            state_q     <= S_VERIFY;
            bit_cnt_q   <= '0;
            bits_left_q <= '0;
            buf_q       <= '0;
          end
        end
        S_VERIFY: begin
          crc_vf_q  <= crc_vf_d;
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            done_q    <= 1'b1;
            err_q     <= (crc_vf_d != crc_ld_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_loader.sv
// Directed bench: a 48-bit chain (8-bit words) and a 12-bit chain with a
// partial final word, each looped back through a behavioural shift register.
module tb_cfg_loader;

  localparam int unsigned LA = 48;
  localparam int unsigned LB = 12;
  localparam int unsigned WW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- 48-bit instance ----------------
  logic          nrst_a, start_a, cfg_en_a, cfg_data_a, cfg_ret_a;
  logic          busy_a, done_a, err_a, flip_a;
  logic [LA-1:0] chain_a;
  logic [7:0]    words_a [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};

  cfg_loader_if #(.WORD_W(WW)) if_a ();

  cfg_loader #(.CHAIN_LEN(LA), .WORD_W(WW)) dut_a (
    .clk      (clk),
    .nrst     (nrst_a),
    .start    (start_a),
    .host     (if_a),
    .cfg_en   (cfg_en_a),
    .cfg_data (cfg_data_a),
    .cfg_ret  (cfg_ret_a),
    .busy     (busy_a),
    .done     (done_a),
    .err      (err_a)
  );

  assign cfg_ret_a = chain_a[LA-1] ^ flip_a;
  always @(posedge clk) begin
    if (!nrst_a)       chain_a <= '0;
    else if (cfg_en_a) chain_a <= {chain_a[LA-2:0], cfg_data_a};
  end

  // ---------------- 12-bit instance ----------------
  logic          nrst_b, start_b, cfg_en_b, cfg_data_b, cfg_ret_b;
  logic          busy_b, done_b, err_b;
  logic [LB-1:0] chain_b;
  logic [7:0]    words_b [3] = '{8'hF0, 8'hAB, 8'h55};

  cfg_loader_if #(.WORD_W(WW)) if_b ();

  cfg_loader #(.CHAIN_LEN(LB), .WORD_W(WW)) dut_b (
    .clk      (clk),
    .nrst     (nrst_b),
    .start    (start_b),
    .host     (if_b),
    .cfg_en   (cfg_en_b),
    .cfg_data (cfg_data_b),
    .cfg_ret  (cfg_ret_b),
    .busy     (busy_b),
    .done     (done_b),
    .err      (err_b)
  );

  assign cfg_ret_b = chain_b[LB-1];
  always @(posedge clk) begin
    if (!nrst_b)       chain_b <= '0;
    else if (cfg_en_b) chain_b <= {chain_b[LB-2:0], cfg_data_b};
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One load on instance A; cycle 0 is the cycle start is presented.
  task automatic run_a(input int stall_lo, input int stall_hi, input int flip_cyc,
                       input int restart1, input int restart2, input int rst_cyc,
                       output int done_cyc, output int en_cnt, output int acc_cnt);
    int   idx;
    logic vld;
    idx      = 0;
    done_cyc = -1;
    en_cnt   = 0;
    acc_cnt  = 0;
    for (int cyc = 0; cyc < 140; cyc++) begin
      start_a        = (cyc == 0) || (cyc == restart1) || (cyc == restart2);
      nrst_a         = (cyc != rst_cyc);
      flip_a         = (cyc == flip_cyc);
      vld            = (idx < 6) && !(cyc >= stall_lo && cyc <= stall_hi);
      if_a.in_valid  = vld;
      if_a.in_data   = (idx < 6) ? words_a[idx] : 8'h00;
      @(negedge clk);
      if (cyc == 1) chk("err_clear_on_start", 64'(err_a), 64'd0);
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_cfg_en", 64'(cfg_en_a), 64'd0);
        chk("rst_in_ready", 64'(if_a.in_ready), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
      end
      if (cfg_en_a) en_cnt++;
      if (done_a && done_cyc < 0) done_cyc = cyc;
      if (vld && if_a.in_ready) begin
        idx++;
        acc_cnt++;
      end
      @(posedge clk);
      #1;
      if (done_cyc >= 0 && cyc == done_cyc) break;
    end
    start_a       = 1'b0;
    nrst_a        = 1'b1;
    flip_a        = 1'b0;
    if_a.in_valid = 1'b0;
  endtask

  initial begin
    int d, e, a, late_rdy, idx_b;
    logic vld_b;

    nrst_a = 1'b0; start_a = 1'b0; flip_a = 1'b0;
    if_a.in_valid = 1'b0; if_a.in_data = '0;
    nrst_b = 1'b0; start_b = 1'b0;
    if_b.in_valid = 1'b0; if_b.in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 64'(busy_a), 64'd0);
    chk("reset_in_ready", 64'(if_a.in_ready), 64'd0);
    chk("reset_cfg_en", 64'(cfg_en_a), 64'd0);
    chk("reset_cfg_data", 64'(cfg_data_a), 64'd0);
    chk("reset_done", 64'(done_a), 64'd0);
    chk("reset_err", 64'(err_a), 64'd0);
    @(posedge clk);
    #1;
    nrst_a = 1'b1;
    nrst_b = 1'b1;
    @(posedge clk);
    #1;

    // Nominal load
    run_a(-1, -1, -1, -1, -1, -1, d, e, a);
    chk("nom_done_cycle", 64'(d), 64'd98);
    chk("nom_en_cycles", 64'(e), 64'd96);
    chk("nom_words", 64'(a), 64'd6);
    chk("nom_err", 64'(err_a), 64'd0);
    chk("nom_chain", 64'(chain_a), 64'hA53C_FF00_817E);
    @(negedge clk);
    chk("nom_done_one_cycle", 64'(done_a), 64'd0);
    chk("nom_idle_busy", 64'(busy_a), 64'd0);
    @(posedge clk);
    #1;

    // Start while busy (in LOAD and in VERIFY) is ignored
    run_a(-1, -1, -1, 30, 60, -1, d, e, a);
    chk("busy_start_done_cycle", 64'(d), 64'd98);
    chk("busy_start_en_cycles", 64'(e), 64'd96);
    chk("busy_start_err", 64'(err_a), 64'd0);
    chk("busy_start_chain", 64'(chain_a), 64'hA53C_FF00_817E);

    // Host stall of 5 cycles before the third word
    run_a(17, 21, -1, -1, -1, -1, d, e, a);
    chk("stall_done_cycle", 64'(d), 64'd103);
    chk("stall_en_cycles", 64'(e), 64'd96);
    chk("stall_err", 64'(err_a), 64'd0);
    chk("stall_chain", 64'(chain_a), 64'hA53C_FF00_817E);

    // Return bit corrupted on the 10th verify cycle (cycle 59)
    run_a(-1, -1, 59, -1, -1, -1, d, e, a);
    chk("fault_done_cycle", 64'(d), 64'd98);
    chk("fault_err", 64'(err_a), 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("fault_err_held", 64'(err_a), 64'd1);
    @(posedge clk);
    #1;

    // Next load clears err (checked at cycle 1 inside the run)
    run_a(-1, -1, -1, -1, -1, -1, d, e, a);
    chk("reload_done_cycle", 64'(d), 64'd98);
    chk("reload_err", 64'(err_a), 64'd0);

    // Reset after 20 load shifts: no done afterwards
    run_a(-1, -1, -1, -1, -1, 22, d, e, a);
    chk("rst_no_done", 64'(d), 64'hFFFF_FFFF_FFFF_FFFF);

    // Odd length: 12-bit chain, F0 then A, nibble B discarded, 0x55 never taken
    idx_b    = 0;
    d        = -1;
    e        = 0;
    a        = 0;
    late_rdy = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      start_b       = (cyc == 0);
      vld_b         = (idx_b < 3);
      if_b.in_valid = vld_b;
      if_b.in_data  = (idx_b < 3) ? words_b[idx_b] : 8'h00;
      @(negedge clk);
      if (a >= 2 && if_b.in_ready) late_rdy++;
      if (cfg_en_b) e++;
      if (done_b && d < 0) d = cyc;
      if (vld_b && if_b.in_ready) begin
        idx_b++;
        a++;
      end
      @(posedge clk);
      #1;
      if (d >= 0 && cyc == d) break;
    end
    start_b       = 1'b0;
    if_b.in_valid = 1'b0;
    chk("odd_done_cycle", 64'(d), 64'd26);
    chk("odd_en_cycles", 64'(e), 64'd24);
    chk("odd_words", 64'(a), 64'd2);
    chk("odd_ready_after_last", 64'(late_rdy), 64'd0);
    chk("odd_chain", 64'(chain_b), 64'h0F0A);
    chk("odd_err", 64'(err_b), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
